// File: rtl/ram_dp_be_rr_arb.sv
// Round-robin arbiter sharing one byte-enable RAM port among REQ_NUM requesters.
// Grant and RAM drive are combinational; rvalid/rdata follow a read grant by one cycle.
// Optional RAM_ARB_LOCK_EN adds lock_i so a winner can hold the port up to LOCK_MAX grants.
module ram_dp_be_rr_arb #(
    parameter int REQ_NUM    = 4,
    parameter int Word_Width = 32,
    parameter int Addr_Width = 8,
    parameter int LOCK_MAX   = 16
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [REQ_NUM-1:0]               req_i,
`ifdef RAM_ARB_LOCK_EN
    input  logic [REQ_NUM-1:0]               lock_i,
`endif
    input  logic [REQ_NUM*(Word_Width/8)-1:0] wen_i,
    input  logic [REQ_NUM*Addr_Width-1:0]    addr_i,
    input  logic [REQ_NUM*Word_Width-1:0]    data_i,
    output logic [REQ_NUM-1:0]               gnt_o,
    output logic [REQ_NUM-1:0]               rvalid_o,
    output logic [Word_Width-1:0]            rdata_o,
    output logic                             ram_cen_o,
    output logic                             ram_oen_o,
    output logic [Word_Width/8-1:0]          ram_wen_o,
    output logic [Addr_Width-1:0]            ram_addr_o,
    output logic [Word_Width-1:0]            ram_data_o,
    input  logic [Word_Width-1:0]            ram_data_i
);
    localparam int BW = Word_Width / 8;
    localparam int PW = $clog2(REQ_NUM);

    if (REQ_NUM < 2 || REQ_NUM > 8 || (Word_Width % 8) != 0 || LOCK_MAX < 1) begin : g_bad_param
        $error("ram_dp_be_rr_arb: unsupported parameter set");
    end

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] x);
        return (x == PW'(REQ_NUM - 1)) ? '0 : x + 1'b1;
    endfunction

    logic [PW-1:0]  ptr, ptr_nxt, base, win, rd_tag;
    logic           found, any_gnt, is_rd, rd_pend;
    logic [BW-1:0]  win_wen;
    int             idx;

`ifdef RAM_ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);
    logic [CW-1:0] lock_cnt, lock_cnt_nxt, cnt_base, cnt_inc;
    logic          lock_on, lock_on_nxt, hold;

    // During an episode ptr parks on the owner; once the owner lets go, search resumes after it.
    assign hold     = lock_on && req_i[ptr] && lock_i[ptr];
    assign base     = (lock_on && !hold) ? inc(ptr) : ptr;
    assign cnt_base = hold ? lock_cnt : '0;
    assign cnt_inc  = cnt_base + 1'b1;

    always_comb begin
        ptr_nxt      = ptr;
        lock_cnt_nxt = '0;
        lock_on_nxt  = 1'b0;
        if (any_gnt) begin
            ptr_nxt = inc(win);
            if (lock_i[win] && cnt_inc != CW'(LOCK_MAX)) begin
                ptr_nxt      = win;
                lock_cnt_nxt = cnt_inc;
                lock_on_nxt  = 1'b1;
            end
        end else if (lock_on) begin
            ptr_nxt = inc(ptr);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lock_cnt <= '0;
            lock_on  <= 1'b0;
        end else begin
            lock_cnt <= lock_cnt_nxt;
            lock_on  <= lock_on_nxt;
        end
    end
`else
    assign base = ptr;

    always_comb begin
        ptr_nxt = ptr;
        if (any_gnt) ptr_nxt = inc(win);
    end
`endif

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < REQ_NUM; i++) begin
            idx = int'(base) + i;
            if (idx >= REQ_NUM) idx = idx - REQ_NUM;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    // Grant is masked by reset so every RAM-side output shows its idle value immediately.
    assign any_gnt = found && rstn;
    assign win_wen = wen_i[win*BW +: BW];
    assign is_rd   = any_gnt && (&win_wen);

    always_comb begin
        gnt_o = '0;
        if (any_gnt) gnt_o[win] = 1'b1;
    end

    assign ram_cen_o  = ~any_gnt;
    assign ram_oen_o  = 1'b0;
    assign ram_wen_o  = any_gnt ? win_wen : '1;
    assign ram_addr_o = any_gnt ? addr_i[win*Addr_Width +: Addr_Width] : '0;
    assign ram_data_o = any_gnt ? data_i[win*Word_Width +: Word_Width] : '0;

    always_comb begin
        rvalid_o = '0;
        if (rd_pend) rvalid_o[rd_tag] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr     <= '0;
            rd_pend <= 1'b0;
            rd_tag  <= '0;
            rdata_o <= '0;
        end else begin
            ptr     <= ptr_nxt;
            rd_pend <= is_rd;
            if (is_rd) begin
                rd_tag  <= win;
                rdata_o <= ram_data_i;
            end
        end
    end
endmodule
